// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package datamem_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int unsigned LOCK_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; owns the last_grant history bit.
module rr_arb2
    import datamem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic       last_grant;
    logic [1:0] eff_req;

    // Pick a single requester directly; on a tie favour the port not granted last.
    always_comb begin
        eff_req = req & mask;
        gnt     = '0;
        case (eff_req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == PORT_PIPE) ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

    // Remember the winner of every committed grant; port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_LOAD;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (port 0)
// and the loader/debug master (port 1), with a bounded port-1 burst lock.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_LOCK      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    input  logic                     m1_lock,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(MAX_LOCK);

    arb_state_t             state, state_nxt;
    logic [LOCK_CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic                   lock_at_max;
    logic [1:0]             mask;
    logic [1:0]             gnt;
    logic [1:0]             rvalid_q;
    logic [DATA_WIDTH-1:0]  m0_rdata_q, m1_rdata_q;

    assign lock_at_max = (lock_cnt == LOCK_MAX);

    // Request gating: nothing during reset, port 1 only while locked,
    // port 0 only on forced release, both when arbitrating normally.
    always_comb begin
        mask = 2'b11;
        if (rst) begin
            mask = 2'b00;
        end else if (state == LOCK1 && m1_lock) begin
            mask = (lock_at_max && m0_req) ? 2'b01 : 2'b10;
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_req, m0_req}),
        .mask    (mask),
        .advance (~rst),
        .gnt     (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Lock FSM next state and burst counter; the counter saturates so a
    // waiting port 0 is always released after MAX_LOCK port-1 grants.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ARB: begin
                if (gnt[1] && m1_lock) begin
                    state_nxt    = LOCK1;
                    lock_cnt_nxt = LOCK_CNT_W'(1);
                end
            end
            LOCK1: begin
                if (!m1_lock || (lock_at_max && m0_req)) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else if (gnt[1] && !lock_at_max) begin
                    lock_cnt_nxt = lock_cnt + LOCK_CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and lock counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Memory drive from the winning port; idle cycles drive zeros.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        case (gnt)
            2'b01: begin
                mem_a  = m0_addr;
                mem_wd = m0_wdata;
                mem_we = m0_we;
            end
            2'b10: begin
                mem_a  = m1_addr;
                mem_wd = m1_wdata;
                mem_we = m1_we;
            end
            default: begin
                mem_a  = '0;
                mem_wd = '0;
                mem_we = 1'b0;
            end
        endcase
    end

    // Read return: capture mem_rd for the granted reader; each port keeps
    // its own data register so the other port's rdata holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rvalid_q <= {gnt[1] & ~m1_we, gnt[0] & ~m0_we};
            if (gnt[0] && !m0_we) begin
                m0_rdata_q <= mem_rd;
            end
            if (gnt[1] && !m1_we) begin
                m1_rdata_q <= mem_rd;
            end
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a behavioural memory and a read scoreboard.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic        pl_en;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;
    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];
    logic [7:0]  mem_idx;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_t;

    rd_t         rdq[$];
    logic [31:0] last_rd [0:1];
    int          tests = 0;
    int          fails = 0;

    datamem_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MAX_LOCK      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_lock   (m1_lock),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Single-port memory with combinational read; preload port for setup.
    assign mem_idx = 8'(mem_a);
    assign mem_rd  = mem[mem_idx];
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_we) mem[mem_idx] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic lock);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lock;
    endtask

    // One cycle: check grant and memory drive mid-cycle, then read return after the edge.
    task automatic tick(input logic [1:0] exp_gnt, input string tag);
        rd_t         e;
        logic [1:0]  exp_rv;
        logic [31:0] a, wd;
        logic        we;
        @(negedge clk);
        chk({tag, " gnt"}, {62'b0, m1_gnt, m0_gnt}, {62'b0, exp_gnt});
        a = '0; wd = '0; we = 1'b0;
        if (exp_gnt == 2'b01) begin a = m0_addr; wd = m0_wdata; we = m0_we; end
        if (exp_gnt == 2'b10) begin a = m1_addr; wd = m1_wdata; we = m1_we; end
        chk({tag, " mem_a"},  {32'b0, mem_a},  {32'b0, a});
        chk({tag, " mem_wd"}, {32'b0, mem_wd}, {32'b0, wd});
        chk({tag, " mem_we"}, {63'b0, mem_we}, {63'b0, we});
        if (exp_gnt != 2'b00) begin
            if (we) shadow[a[7:0]] = wd;
            else rdq.push_back('{port: exp_gnt[1], data: shadow[a[7:0]]});
        end
        @(posedge clk);
        #1;
        exp_rv = 2'b00;
        if (rdq.size() > 0) begin
            e = rdq.pop_front();
            exp_rv = e.port ? 2'b10 : 2'b01;
            last_rd[e.port] = e.data;
        end
        chk({tag, " rvalid"},   {62'b0, m1_rvalid, m0_rvalid}, {62'b0, exp_rv});
        chk({tag, " m0_rdata"}, {32'b0, m0_rdata}, {32'b0, last_rd[0]});
        chk({tag, " m1_rdata"}, {32'b0, m1_rdata}, {32'b0, last_rd[1]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst = 1'b1;
        set_m0(1'b1, 1'b1, 32'h10, 32'h1);
        set_m1(1'b1, 1'b1, 32'h10, 32'h2, 1'b0);
        pl_en = 1'b1; pl_a = 8'h10; pl_d = 32'hDEADBEEF;
        shadow[8'h10] = 32'hDEADBEEF;

        // Reset state with both ports requesting writes.
        @(negedge clk);
        chk("rst gnt",    {62'b0, m1_gnt, m0_gnt},       64'h0);
        chk("rst mem_we", {63'b0, mem_we},               64'h0);
        chk("rst rvalid", {62'b0, m1_rvalid, m0_rvalid}, 64'h0);
        chk("rst rdata",  {m1_rdata, m0_rdata},          64'h0);
        @(posedge clk); #1;
        pl_a = 8'h04; pl_d = 32'h0; shadow[8'h04] = 32'h0;
        @(posedge clk); #1;
        pl_en = 1'b0;
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;

        // Basic read, write, read-after-write.
        set_m0(1'b1, 1'b0, 32'h10, '0);             tick(2'b01, "m0_rd");
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b1, 1'b1, 32'h4, 32'h55, 1'b0);    tick(2'b10, "m1_wr");
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);
        set_m0(1'b1, 1'b0, 32'h4, '0);              tick(2'b01, "raw");
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b1, 1'b0, 32'h10, '0, 1'b0);       tick(2'b10, "m1_rd");

        // Continuous contention alternates 0,1,0,1.
        set_m0(1'b1, 1'b0, 32'h10, '0);
        set_m1(1'b1, 1'b1, 32'h8, 32'hA1, 1'b0);    tick(2'b01, "rr0");
        set_m0(1'b1, 1'b0, 32'h8, '0);              tick(2'b10, "rr1");
        set_m1(1'b1, 1'b0, 32'h4, '0, 1'b0);        tick(2'b01, "rr2");
        set_m0(1'b1, 1'b1, 32'h30, 32'h33);         tick(2'b10, "rr3");
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);           tick(2'b01, "m0_wr30");

        // Locked burst: 8 port-1 grants, forced port-0 grant, then re-lock.
        set_m0(1'b1, 1'b0, 32'h30, '0);
        for (int i = 0; i < 8; i++) begin
            set_m1(1'b1, 1'b0, (i % 2 == 0) ? 32'h4 : 32'h10, '0, 1'b1);
            tick(2'b10, "lock_m1");
        end
        tick(2'b01, "forced");
        set_m0(1'b1, 1'b1, 32'h20, 32'h77);
        for (int i = 0; i < 3; i++) tick(2'b10, "relock");

        // Idle cycles under lock neither grant nor advance the counter.
        set_m1(1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) tick(2'b00, "lock_idle");
        set_m1(1'b1, 1'b0, 32'h4, '0, 1'b1);
        for (int i = 0; i < 5; i++) tick(2'b10, "lock_resume");
        tick(2'b01, "forced2");

        // Dropping the lock hands the same cycle to ARB rules.
        set_m0(1'b1, 1'b0, 32'h20, '0);             tick(2'b10, "lock_again");
        set_m1(1'b0, 1'b0, '0, '0, 1'b1);           tick(2'b00, "lock_hold");
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);           tick(2'b01, "unlock");

        // Reset right after a granted port-1 read drops the pending rvalid.
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b1, 1'b0, 32'h8, '0, 1'b0);
        @(negedge clk);
        chk("pre_rst gnt", {62'b0, m1_gnt, m0_gnt}, 64'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst rvalid", {62'b0, m1_rvalid, m0_rvalid}, 64'h0);
        chk("midrst rdata",  {m1_rdata, m0_rdata},          64'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        set_m0(1'b1, 1'b1, 32'h40, 32'h99);
        set_m1(1'b1, 1'b1, 32'h40, 32'hAA, 1'b0);
        @(negedge clk);
        chk("midrst gnt",    {62'b0, m1_gnt, m0_gnt}, 64'h0);
        chk("midrst mem_we", {63'b0, mem_we},         64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2'b01, "post_rst_tie");
        set_m0(1'b1, 1'b0, 32'h40, '0);             tick(2'b10, "post_rst_m1");
        set_m1(1'b0, 1'b0, '0, '0, 1'b0);           tick(2'b01, "post_rst_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
